step_phase_decoder: RTL

STEP_PHASE_DECODER -- requirements
Module: step_phase_decoder

---
 rtl/step_phase_decoder.sv | 118 +++++++++++
 1 files changed

// File: rtl/step_phase_decoder.sv
// step_phase_decoder: decodes a stepper coil pattern into steps, position, period and stall status
module step_phase_decoder #(
  parameter int POS_W = 16,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic [3:0]              phase_in,
  input  logic                    clear,
  output logic                    step_evt,
  output logic                    step_dir,
  output logic                    step_full,
  output logic signed [POS_W-1:0] position,
  output logic [31:0]             period,
  output logic                    period_valid,
  output logic                    illegal_err,
  output logic                    stalled,
  output logic                    locked
);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t state, state_nx;
  logic [3:0] s1, s2;
  logic legal, off, do_step, fwd, full, set_err;
  logic [2:0] idx, ref_idx, ref_nx, delta;
  logic [POS_W-1:0] inc;
  logic [31:0] cnt;
  logic first_done;
  // Pattern-to-index lookup on the synchronized coil pattern
  always_comb begin
    legal = 1'b1;
    idx = 3'd0;
    case (s2)
      4'b1000: idx = 3'd0;
      4'b1100: idx = 3'd1;
      4'b0100: idx = 3'd2;
      4'b0110: idx = 3'd3;
      4'b0010: idx = 3'd4;
      4'b0011: idx = 3'd5;
      4'b0001: idx = 3'd6;
      4'b1001: idx = 3'd7;
      default: legal = 1'b0;
    endcase
  end
  assign off = s2 == 4'b0000;
  assign delta = idx - ref_idx;
  assign inc = full ? POS_W'(2) : POS_W'(1);
  assign locked = state == LOCKED;
  assign stalled = locked && cnt >= 32'(TIMEOUT_CYCLES);
  // Two-flop synchronizer for the asynchronous coil pattern
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      s1 <= 4'b0000;
      s2 <= 4'b0000;
    end else begin
      s1 <= phase_in;
      s2 <= s1;
    end
  // Lock state register
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) state <= UNLOCKED;
    else state <= state_nx;
  // Next-state and step classification from the index delta
  always_comb begin
    state_nx = state;
    ref_nx = ref_idx;
    do_step = 1'b0;
    fwd = 1'b0;
    full = 1'b0;
    set_err = 1'b0;
    if (state == UNLOCKED) begin
      if (legal) begin
        state_nx = LOCKED;
        ref_nx = idx;
      end else set_err = !off;
    end else if (!legal) begin
      state_nx = UNLOCKED;
      set_err = !off;
    end else begin
      ref_nx = idx;
      do_step = delta inside {3'd1, 3'd2, 3'd6, 3'd7};
      fwd = delta inside {3'd1, 3'd2};
      full = delta inside {3'd2, 3'd6};
      set_err = delta inside {3'd3, 3'd4, 3'd5};
    end
  end
  // Step outputs, position, cycle counter, period and sticky error
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      ref_idx <= 3'd0;
      step_evt <= 1'b0;
      step_dir <= 1'b1;
      step_full <= 1'b0;
      position <= '0;
      cnt <= '0;
      first_done <= 1'b0;
      period <= '0;
      period_valid <= 1'b0;
      illegal_err <= 1'b0;
    end else begin
      ref_idx <= ref_nx;
      step_evt <= do_step;
      if (do_step) begin
        step_dir <= fwd;
        step_full <= full;
      end
      if (clear) position <= '0;
      else if (do_step) position <= fwd ? position + inc : position - inc;
      if (state != LOCKED) cnt <= '0;
      else if (do_step) cnt <= 32'd1;
      else if (cnt != '1) cnt <= cnt + 32'd1;
      if (state != LOCKED) first_done <= 1'b0;
      else if (do_step) first_done <= 1'b1;
      if (do_step && first_done) period <= cnt;
      if (state_nx == UNLOCKED) period_valid <= 1'b0;
      else if (do_step && first_done) period_valid <= 1'b1;
      if (set_err) illegal_err <= 1'b1;
    end
endmodule
